// File: rtl/serial_slice_comparator.sv
// rtl/serial_slice_comparator.sv - multi-cycle magnitude comparator sharing one 2-bit slice compare cell

// Compares one 2-bit slice pair; the only compare logic in the comparator.
module slice_cmp2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic       gt_o,
    output logic       eq_o,
    output logic       lt_o
);

    // Purely combinational 2-bit magnitude compare.
    always_comb begin
        gt_o = (a_i > b_i);
        eq_o = (a_i == b_i);
        lt_o = (a_i < b_i);
    end

endmodule

// Walks the operand slices MSB first through the shared cell and registers a one-hot result.
module serial_slice_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NS = WIDTH / 2;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             dgt_q, dgt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic [1:0]       a_sl;
    logic [1:0]       b_sl;
    logic             cell_gt;
    logic             cell_eq;
    logic             cell_lt;
    logic             slice_ne;
    logic             finish;

    // Route the slice selected by idx into the shared cell.
    always_comb begin
        a_sl = 2'b00;
        b_sl = 2'b00;
        for (int i = 0; i < NS; i++) begin
            if (idx_q == IW'(i)) begin
                a_sl = a_q[2*i +: 2];
                b_sl = b_q[2*i +: 2];
            end
        end
    end

    slice_cmp2 u_cell (
        .a_i  (a_sl),
        .b_i  (b_sl),
        .gt_o (cell_gt),
        .eq_o (cell_eq),
        .lt_o (cell_lt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath next values and the final one-hot result.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        dgt_d     = dgt_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        slice_ne  = !cell_eq;
        finish    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    idx_d     = IDX_TOP;
                    decided_d = 1'b0;
                    dgt_d     = 1'b0;
                    state_d   = S_COMPARE;
                end
            end
            S_COMPARE: begin
                // The most significant unequal slice wins; later slices are ignored.
                if (!decided_q && slice_ne) begin
                    decided_d = 1'b1;
                    dgt_d     = cell_gt;
                end
                finish = (idx_q == '0) || (EARLY_EXIT && slice_ne);
                if (finish) begin
                    state_d = S_DONE;
                    // Load the outputs now so they change in the DONE cycle.
                    if (decided_q) begin
                        gt_d = dgt_q;
                        eq_d = 1'b0;
                        lt_d = !dgt_q;
                    end else if (slice_ne) begin
                        gt_d = cell_gt;
                        eq_d = 1'b0;
                        lt_d = cell_lt;
                    end else begin
                        gt_d = 1'b0;
                        eq_d = 1'b1;
                        lt_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand, scan and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            dgt_q     <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            dgt_q     <= dgt_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule
